// File: rtl/calc_entry_sequencer_if.sv
// Keypad calculator sequencer bus: keypad codes in, ALU start/done handshake, display outputs.
// The sequencer side uses the master modport; the keypad/ALU/display environment uses slave.
interface calc_entry_sequencer_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] disp_val;
    logic [1:0]  disp_sel;
    logic        busy;
    logic        error;

    modport master (
        input  key_valid, key_code, alu_done, alu_result,
        output alu_start, op_a, op_b, disp_val, disp_sel, busy, error
    );

    modport slave (
        output key_valid, key_code, alu_done, alu_result,
        input  alu_start, op_a, op_b, disp_val, disp_sel, busy, error
    );
endinterface

// File: rtl/calc_entry_sequencer.sv
// Collects two BCD operands from keypad codes, launches the ALU and holds its result for display.
// One cycle per key; keys are dropped while busy and alu_done is dropped outside WAIT (no backpressure).
module calc_entry_sequencer #(
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    calc_entry_sequencer_if.master bus
);
    localparam int          TW    = $clog2(TIMEOUT);
    localparam logic [2:0]  MAXD  = 3'(MAX_DIGITS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_OPA, S_OPB, S_START, S_WAIT, S_SHOW} state_t;

    state_t          state, state_nxt;
    logic [15:0]     ent_q, ent_nxt;
    logic [2:0]      cnt_q, cnt_nxt;
    logic [2:0]      cnt_a_q, cnt_a_nxt;
    logic [15:0]     op_a_q, op_a_nxt;
    logic [15:0]     op_b_q, op_b_nxt;
    logic [15:0]     res_q, res_nxt;
    logic [15:0]     disp_q, disp_nxt;
    logic [TW-1:0]   tmo_q, tmo_nxt;
    logic            err_q, err_nxt;
    logic            key_digit, key_enter, key_del;

    assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_enter = bus.key_valid && (bus.key_code == 4'hB);
    assign key_del   = bus.key_valid && (bus.key_code == 4'hC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_OPA;
            ent_q   <= '0;
            cnt_q   <= '0;
            cnt_a_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ent_q   <= ent_nxt;
            cnt_q   <= cnt_nxt;
            cnt_a_q <= cnt_a_nxt;
            op_a_q  <= op_a_nxt;
            op_b_q  <= op_b_nxt;
            res_q   <= res_nxt;
            disp_q  <= disp_nxt;
            tmo_q   <= tmo_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ent_nxt   = ent_q;
        cnt_nxt   = cnt_q;
        cnt_a_nxt = cnt_a_q;
        op_a_nxt  = op_a_q;
        op_b_nxt  = op_b_q;
        res_nxt   = res_q;
        tmo_nxt   = tmo_q;
        err_nxt   = err_q;

        case (state)
            S_OPA, S_OPB: begin
                if (key_digit) begin
                    // A full buffer swallows further digits rather than shifting the oldest out
                    if (cnt_q < MAXD) begin
                        ent_nxt = {ent_q[11:0], bus.key_code};
                        cnt_nxt = cnt_q + 3'd1;
                    end
                end else if (key_del) begin
                    if (cnt_q != 3'd0) begin
                        ent_nxt = {4'h0, ent_q[15:4]};
                        cnt_nxt = cnt_q - 3'd1;
                    end else if (state == S_OPB) begin
                        // Backing out of an empty B reopens A for editing
                        state_nxt = S_OPA;
                        ent_nxt   = op_a_q;
                        cnt_nxt   = cnt_a_q;
                    end
                end else if (key_enter && (cnt_q != 3'd0)) begin
                    if (state == S_OPA) begin
                        op_a_nxt  = ent_q;
                        cnt_a_nxt = cnt_q;
                        ent_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_OPB;
                    end else begin
                        op_b_nxt  = ent_q;
                        state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                tmo_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                tmo_nxt = tmo_q + 1'b1;
                if (bus.alu_done) begin
                    res_nxt   = bus.alu_result;
                    state_nxt = S_SHOW;
                end else if (tmo_q == TLAST) begin
                    err_nxt   = 1'b1;
                    res_nxt   = 16'hEEEE;
                    state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (bus.key_valid) begin
                    err_nxt   = 1'b0;
                    ent_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_OPA;
                    if (key_digit) begin
                        ent_nxt = {12'h000, bus.key_code};
                        cnt_nxt = 3'd1;
                    end
                end
            end
            default: state_nxt = S_OPA;
        endcase
    end

    // Display value follows the post-transition state so it never lags the context
    always_comb begin
        disp_nxt = ent_nxt;
        case (state_nxt)
            S_START, S_WAIT: disp_nxt = op_b_nxt;
            S_SHOW:          disp_nxt = res_nxt;
            default:         disp_nxt = ent_nxt;
        endcase
    end

    always_comb begin
        bus.disp_sel = 2'd0;
        case (state)
            S_OPB:           bus.disp_sel = 2'd1;
            S_START, S_WAIT: bus.disp_sel = 2'd2;
            S_SHOW:          bus.disp_sel = 2'd3;
            default:         bus.disp_sel = 2'd0;
        endcase
    end

    assign bus.alu_start = (state == S_START);
    assign bus.busy      = (state == S_START) || (state == S_WAIT);
    assign bus.error     = err_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.disp_val  = disp_q;
endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Bench for calc_entry_sequencer: vector table, directed corner sequences, randomized run vs. model.
module tb_calc_entry_sequencer;
    localparam int TO   = 16;
    localparam int MAXD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    calc_entry_sequencer_if bus_if();

    calc_entry_sequencer #(.MAX_DIGITS(MAXD), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        ad;
        logic [15:0] ar;
        logic [52:0] exp;
    } vec_t;

    function automatic logic [52:0] mk(input logic s, input logic b, input logic e,
                                       input logic [1:0] sel, input logic [15:0] d,
                                       input logic [15:0] a, input logic [15:0] bb);
        return {s, b, e, sel, d, a, bb};
    endfunction

    function automatic logic [52:0] obs();
        return {bus_if.alu_start, bus_if.busy, bus_if.error, bus_if.disp_sel,
                bus_if.disp_val, bus_if.op_a, bus_if.op_b};
    endfunction

    task automatic chk(input string nm, input logic [52:0] act, input logic [52:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got start=%b busy=%b err=%b sel=%0d disp=%h a=%h b=%h, want start=%b busy=%b err=%b sel=%0d disp=%h a=%h b=%h",
                      nm, act[52], act[51], act[50], act[49:48], act[47:32], act[31:16], act[15:0],
                      exp[52], exp[51], exp[50], exp[49:48], exp[47:32], exp[31:16], exp[15:0]);
    endtask

    // Called just after an edge: present inputs, take the next edge, then retire the pulses
    task automatic tick(input logic kv, input logic [3:0] kc, input logic ad, input logic [15:0] ar);
        bus_if.key_valid  = kv;
        bus_if.key_code   = kc;
        bus_if.alu_done   = ad;
        bus_if.alu_result = ar;
        @(posedge clk);
        #1;
        bus_if.key_valid = 1'b0;
        bus_if.alu_done  = 1'b0;
    endtask

    task automatic key(input logic [3:0] kc);
        tick(1'b1, kc, 1'b0, 16'h0);
    endtask

    task automatic idle();
        tick(1'b0, 4'h0, 1'b0, 16'h0);
    endtask

    // Reference model: operands as digit lists, phases 0=A 1=B 2=launch 3=waiting 4=show
    int          phase;
    int          digs[$];
    int          a_digs[$];
    logic [15:0] m_opa, m_opb, m_res;
    int          waited;
    logic        m_err;

    function automatic logic [15:0] pack_digs();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return 16'(v);
    endfunction

    task automatic model_reset();
        phase = 0; digs = {}; a_digs = {};
        m_opa = 0; m_opb = 0; m_res = 0; waited = 0; m_err = 0;
    endtask

    task automatic model_step(input logic kv, input int kc, input logic ad, input logic [15:0] ar);
        case (phase)
            0, 1: if (kv) begin
                if (kc <= 9) begin
                    if (digs.size() < MAXD) digs.push_back(kc);
                end else if (kc == 12) begin
                    if (digs.size() > 0) void'(digs.pop_back());
                    else if (phase == 1) begin phase = 0; digs = a_digs; end
                end else if (kc == 11 && digs.size() > 0) begin
                    if (phase == 0) begin
                        m_opa = pack_digs(); a_digs = digs; digs = {}; phase = 1;
                    end else begin
                        m_opb = pack_digs(); phase = 2;
                    end
                end
            end
            2: begin phase = 3; waited = 0; end
            3: begin
                waited++;
                if (ad) begin m_res = ar; phase = 4; end
                else if (waited == TO) begin m_err = 1; m_res = 16'hEEEE; phase = 4; end
            end
            default: if (kv) begin
                m_err = 0; digs = {}; phase = 0;
                if (kc <= 9) digs.push_back(kc);
            end
        endcase
    endtask

    function automatic logic [52:0] model_out();
        logic [1:0]  sel;
        logic [15:0] d;
        sel = (phase == 0) ? 2'd0 : (phase == 1) ? 2'd1 : (phase == 4) ? 2'd3 : 2'd2;
        d   = (phase <= 1) ? pack_digs() : (phase == 4) ? m_res : m_opb;
        return mk(phase == 2, phase == 2 || phase == 3, m_err, sel, d, m_opa, m_opb);
    endfunction

    vec_t tbl[10];

    initial begin
        logic [3:0]  kc;
        logic        kv, ad;
        logic [15:0] ar;
        int          r;

        tbl[0] = '{1'b1, 4'h1, 1'b0, 16'h0, mk(0,0,0,2'd0,16'h0001,16'h0000,16'h0000)};
        tbl[1] = '{1'b1, 4'h2, 1'b0, 16'h0, mk(0,0,0,2'd0,16'h0012,16'h0000,16'h0000)};
        tbl[2] = '{1'b1, 4'h3, 1'b0, 16'h0, mk(0,0,0,2'd0,16'h0123,16'h0000,16'h0000)};
        tbl[3] = '{1'b1, 4'hB, 1'b0, 16'h0, mk(0,0,0,2'd1,16'h0000,16'h0123,16'h0000)};
        tbl[4] = '{1'b1, 4'h4, 1'b0, 16'h0, mk(0,0,0,2'd1,16'h0004,16'h0123,16'h0000)};
        tbl[5] = '{1'b1, 4'h5, 1'b0, 16'h0, mk(0,0,0,2'd1,16'h0045,16'h0123,16'h0000)};
        tbl[6] = '{1'b1, 4'hB, 1'b0, 16'h0, mk(1,1,0,2'd2,16'h0045,16'h0123,16'h0045)};
        tbl[7] = '{1'b1, 4'h7, 1'b0, 16'h0, mk(0,1,0,2'd2,16'h0045,16'h0123,16'h0045)};
        tbl[8] = '{1'b0, 4'h0, 1'b0, 16'h0, mk(0,1,0,2'd2,16'h0045,16'h0123,16'h0045)};
        tbl[9] = '{1'b0, 4'h0, 1'b1, 16'h0168, mk(0,0,0,2'd3,16'h0168,16'h0123,16'h0045)};

        bus_if.key_valid = 0; bus_if.key_code = 0; bus_if.alu_done = 0; bus_if.alu_result = 0;
        #1;
        chk("reset_state", obs(), mk(0,0,0,2'd0,16'h0,16'h0,16'h0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].kv, tbl[i].kc, tbl[i].ad, tbl[i].ar);
            chk($sformatf("table_row%0d", i), obs(), tbl[i].exp);
        end

        // Digit overflow, delete, and enter on an empty B buffer
        key(4'h9);
        chk("show_digit_starts_a", obs(), mk(0,0,0,2'd0,16'h0009,16'h0123,16'h0045));
        key(4'h8); key(4'h7); key(4'h6);
        chk("digit_overflow", obs(), mk(0,0,0,2'd0,16'h0987,16'h0123,16'h0045));
        key(4'hC);
        chk("delete_shift", obs(), mk(0,0,0,2'd0,16'h0098,16'h0123,16'h0045));
        key(4'hB);
        chk("enter_a", obs(), mk(0,0,0,2'd1,16'h0000,16'h0098,16'h0045));
        key(4'hB);
        chk("enter_empty_b", obs(), mk(0,0,0,2'd1,16'h0000,16'h0098,16'h0045));

        // Delete past an empty B back into A, and delete on an empty A
        key(4'hC);
        chk("del_b_to_a", obs(), mk(0,0,0,2'd0,16'h0098,16'h0098,16'h0045));
        key(4'hC); key(4'hC); key(4'hC);
        chk("del_empty_a", obs(), mk(0,0,0,2'd0,16'h0000,16'h0098,16'h0045));
        key(4'h1); key(4'h2); key(4'hB); key(4'hC);
        chk("restore_a_0012", obs(), mk(0,0,0,2'd0,16'h0012,16'h0012,16'h0045));
        key(4'h3);
        chk("append_after_restore", obs(), mk(0,0,0,2'd0,16'h0123,16'h0012,16'h0045));

        // Timeout path
        key(4'hB); key(4'h5); key(4'hB);
        chk("launch2", obs(), mk(1,1,0,2'd2,16'h0005,16'h0123,16'h0005));
        for (int i = 0; i < TO; i++) idle();
        chk("wait_before_timeout", obs(), mk(0,1,0,2'd2,16'h0005,16'h0123,16'h0005));
        idle();
        chk("timeout", obs(), mk(0,0,1,2'd3,16'hEEEE,16'h0123,16'h0005));
        key(4'h7);
        chk("clear_error", obs(), mk(0,0,0,2'd0,16'h0007,16'h0123,16'h0005));

        // alu_done in the final waiting cycle beats the timeout
        key(4'hB); key(4'h2); key(4'hB);
        for (int i = 0; i < TO; i++) idle();
        tick(1'b0, 4'h0, 1'b1, 16'h1234);
        chk("done_at_timeout", obs(), mk(0,0,0,2'd3,16'h1234,16'h0007,16'h0002));

        // Asynchronous reset during WAIT, then a stale alu_done
        key(4'h4); key(4'hB); key(4'h1); key(4'hB); idle(); idle();
        chk("in_wait", obs(), mk(0,1,0,2'd2,16'h0001,16'h0004,16'h0001));
        #2 rst = 1'b1;
        #1;
        chk("async_reset", obs(), mk(0,0,0,2'd0,16'h0,16'h0,16'h0));
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        tick(1'b0, 4'h0, 1'b1, 16'h5555);
        chk("stale_done_ignored", obs(), mk(0,0,0,2'd0,16'h0,16'h0,16'h0));

        // Randomized run against the model
        rst = 1'b1; #2 rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            kv = ($urandom_range(0, 9) < 4);
            r  = $urandom_range(0, 9);
            kc = (r < 6) ? 4'($urandom_range(0, 9)) : (r < 8) ? 4'hB : (r < 9) ? 4'hC : 4'($urandom_range(0, 15));
            ad = ($urandom_range(0, 39) == 0);
            ar = 16'($urandom);
            model_step(kv, int'(kc), ad, ar);
            tick(kv, kc, ad, ar);
            chk($sformatf("random_cycle%0d", c), obs(), model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
